// File: rtl/load_frame.sv
// Replays a stored 1-bit-per-pixel frame from a row-wide synchronous RAM as a
// valid/ready pixel stream in raster order for a downstream VGA writer.
module load_frame #(
  parameter int unsigned ROWS         = 480,
  parameter int unsigned COLS         = 640,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic            load_sw,
  output logic [8:0]      read_addr,
  input  logic [COLS-1:0] q,
  input  logic            pixel_ready,
  output logic            pixel_valid,
  output logic [10:0]     x,
  output logic [10:0]     y,
  output logic            pixel_color,
  output logic            done
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAPTURE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic [ROW_W-1:0] row, row_next;
  logic [COL_W-1:0] col, col_next;
  logic [LAT_W-1:0] lat, lat_next;
  logic [COLS-1:0]  line, line_next;
  logic             valid_next;
  logic             color_next;
  logic             done_next;

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, counters and the values the registered outputs will take
  always_comb begin
    state_next = state;
    row_next   = row;
    col_next   = col;
    lat_next   = lat;
    line_next  = line;

    if (state != S_IDLE && !load_sw) begin
      state_next = S_IDLE;
      row_next   = '0;
      col_next   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          row_next = '0;
          col_next = '0;
          if (load_sw) state_next = S_REQ;
        end
        S_REQ: begin
          lat_next   = LAT_LOAD;
          state_next = S_WAIT;
        end
        S_WAIT: begin
          if (lat == '0) state_next = S_CAPTURE;
          else           lat_next   = lat - LAT_W'(1);
        end
        S_CAPTURE: begin
          line_next  = q;
          col_next   = '0;
          state_next = S_SCAN;
        end
        S_SCAN: begin
          // Column and row saturate at their last index instead of wrapping
          if (pixel_ready) begin
            if (col == COL_LAST) begin
              if (row == ROW_LAST) begin
                state_next = S_DONE;
              end else begin
                row_next   = row + ROW_W'(1);
                state_next = S_REQ;
              end
            end else begin
              col_next = col + COL_W'(1);
            end
          end
        end
        S_DONE: begin
          state_next = S_DONE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end

    valid_next = (state_next == S_SCAN);
    color_next = valid_next & line_next[col_next];
    done_next  = (state_next == S_DONE);
  end

  // Datapath and registered outputs
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      row         <= '0;
      col         <= '0;
      lat         <= '0;
      line        <= '0;
      read_addr   <= '0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      pixel_color <= 1'b0;
      done        <= 1'b0;
    end else begin
      row         <= row_next;
      col         <= col_next;
      lat         <= lat_next;
      line        <= line_next;
      read_addr   <= 9'(row_next);
      pixel_valid <= valid_next;
      x           <= 11'(col_next);
      y           <= 11'(row_next);
      pixel_color <= color_next;
      done        <= done_next;
    end
  end

endmodule

// File: tb/tb_load_frame.sv
// Bench for load_frame: RAM model, random back-pressure, raster-order reference
// model checked every cycle, plus directed abort/reset/latency scenarios.
module tb_load_frame;

  localparam int ROWS = 40;
  localparam int COLS = 128;
  localparam int RL   = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            load_sw = 1'b0;
  logic [8:0]      read_addr;
  logic [COLS-1:0] q;
  logic            pixel_ready = 1'b1;
  logic            pixel_valid;
  logic [10:0]     x;
  logic [10:0]     y;
  logic            pixel_color;
  logic            done;

  int     err = 0;
  int     chk = 0;
  longint cyc = 0;
  bit     rnd_ready = 1'b0;

  logic [COLS-1:0] mem [512];
  logic [COLS-1:0] st1, st2, noise;

  // Reference model state: pixel expected next and remaining overhead cycles
  bit m_run = 1'b0;
  bit m_fin = 1'b0;
  int m_ex  = 0;
  int m_ey  = 0;
  int m_ovh = 0;
  int dut_hs = 0;

  load_frame #(.ROWS(ROWS), .COLS(COLS), .READ_LATENCY(RL)) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .load_sw     (load_sw),
    .read_addr   (read_addr),
    .q           (q),
    .pixel_ready (pixel_ready),
    .pixel_valid (pixel_valid),
    .x           (x),
    .y           (y),
    .pixel_color (pixel_color),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-cycle RAM; q is scrambled while row 5 is being scanned
  always @(posedge clk) begin
    st1   <= mem[read_addr];
    st2   <= st1;
    noise <= {$urandom, $urandom, $urandom, $urandom};
  end
  assign q = (pixel_valid && y == 11'd5) ? (st2 ^ noise) : st2;

  always @(posedge clk) begin
    if (!load_sw) dut_hs <= 0;
    else if (pixel_valid && pixel_ready) dut_hs <= dut_hs + 1;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      pixel_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    chk++;
    if (!ok) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_mem();
    for (int r = 0; r < 512; r++)
      mem[r] = (r < ROWS) ? {$urandom, $urandom, $urandom, $urandom} : '0;
  endtask

  // Model: each row costs RL+2 idle cycles then COLS accepted pixels in order
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || !load_sw) begin
      m_run <= 1'b0;
      m_fin <= 1'b0;
      m_ex  <= 0;
      m_ey  <= 0;
      m_ovh <= 0;
    end else if (!m_run) begin
      m_run <= 1'b1;
      m_ovh <= RL + 2;
    end else if (m_fin) begin
      m_fin <= 1'b1;
    end else if (m_ovh != 0) begin
      m_ovh <= m_ovh - 1;
    end else if (pixel_ready) begin
      if (m_ex == COLS - 1) begin
        if (m_ey == ROWS - 1) begin
          m_fin <= 1'b1;
        end else begin
          m_ey  <= m_ey + 1;
          m_ex  <= 0;
          m_ovh <= RL + 2;
        end
      end else begin
        m_ex <= m_ex + 1;
      end
    end
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (!m_run) begin
      check({pixel_valid, done, pixel_color, x, y, read_addr} == '0, "idle_outputs",
            longint'({pixel_valid, done, pixel_color, x, y, read_addr}), 0);
    end else if (m_fin) begin
      check(done == 1'b1 && pixel_valid == 1'b0, "done_state", longint'({done, pixel_valid}), 2);
    end else if (m_ovh != 0) begin
      check(pixel_valid == 1'b0, "overhead_valid", longint'(pixel_valid), 0);
      check(int'(read_addr) == m_ey, "overhead_addr", longint'(read_addr), m_ey);
    end else begin
      check(pixel_valid == 1'b1 && done == 1'b0, "scan_valid", longint'({pixel_valid, done}), 2);
      check(int'(x) == m_ex, "pixel_x", longint'(x), m_ex);
      check(int'(y) == m_ey, "pixel_y", longint'(y), m_ey);
      check(pixel_color == mem[m_ey][m_ex], "pixel_color", longint'(pixel_color),
            longint'(mem[m_ey][m_ex]));
    end
  end

  initial begin
    longint t0;
    int n;
    fill_mem();
    mem[0] = '0;
    mem[0][0] = 1'b1;
    mem[0][COLS-1] = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Frame A: full rate, literal latency and timing expectations
    t0 = cyc;
    load_sw = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pixel_valid && n < 100) begin @(negedge clk); n++; end
    check(cyc - t0 == 5, "first_pixel_latency", cyc - t0, 5);
    check(x == 11'd0 && y == 11'd0, "first_pixel_xy", longint'({x, y}), 0);
    check(pixel_color == 1'b1, "color_0_0", longint'(pixel_color), 1);
    @(negedge clk);
    check(x == 11'd1 && pixel_color == 1'b0, "color_1_0", longint'({x, pixel_color}), 2);
    n = 0;
    while (!(pixel_valid && int'(x) == COLS - 1) && n < 1000) begin @(negedge clk); n++; end
    check(pixel_color == 1'b1 && y == 11'd0, "color_last_0", longint'({y, pixel_color}), 1);
    n = 0;
    while (!done && n < 20000) begin @(negedge clk); n++; end
    check(cyc - t0 == 1 + ROWS * (COLS + RL + 2), "done_time", cyc - t0, 1 + ROWS * (COLS + RL + 2));
    check(dut_hs == ROWS * COLS, "frame_a_handshakes", dut_hs, ROWS * COLS);
    repeat (20) @(negedge clk);
    check(done == 1'b1 && pixel_valid == 1'b0, "done_hold", longint'({done, pixel_valid}), 2);
    @(posedge clk); #1 load_sw = 1'b0;
    repeat (5) @(posedge clk);

    // Frame B: random back-pressure, fresh RAM contents
    fill_mem();
    rnd_ready = 1'b1;
    #1 load_sw = 1'b1;
    n = 0;
    while (!done && n < 30000) begin @(negedge clk); n++; end
    check(n < 30000, "frame_b_done", n, 30000);
    check(dut_hs == ROWS * COLS, "frame_b_handshakes", dut_hs, ROWS * COLS);
    @(posedge clk); #1 load_sw = 1'b0;
    repeat (5) @(posedge clk);

    // Abort at (100,37), then replay from (0,0)
    #1 load_sw = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(pixel_valid && x == 11'd100 && y == 11'd37) && n < 30000) begin @(negedge clk); n++; end
    check(n < 30000, "abort_point_reached", n, 30000);
    load_sw = 1'b0;
    @(negedge clk);
    check(pixel_valid == 1'b0, "abort_valid", longint'(pixel_valid), 0);
    repeat (4) @(posedge clk);
    #1 load_sw = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pixel_valid && n < 100) begin @(negedge clk); n++; end
    check(x == 11'd0 && y == 11'd0 && n < 100, "restart_xy", longint'({x, y}), 0);
    rnd_ready = 1'b0;

    // Asynchronous reset in the WAIT of row 20
    n = 0;
    while (!(pixel_valid && y == 11'd19 && int'(x) == COLS - 1) && n < 30000) begin
      @(negedge clk); n++;
    end
    check(n < 30000, "row19_end_reached", n, 30000);
    @(posedge clk);
    @(posedge clk);
    #2;
    check(read_addr == 9'd20 && pixel_valid == 1'b0, "pre_reset_wait",
          longint'({read_addr, pixel_valid}), 40);
    reset_n = 1'b0;
    load_sw = 1'b0;
    #1;
    check({pixel_valid, done, pixel_color, x, y, read_addr} == '0, "async_reset",
          longint'({pixel_valid, done, pixel_color, x, y, read_addr}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check(pixel_valid == 1'b0, "no_restart_after_reset", longint'(pixel_valid), 0);
    load_sw = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done && n < 20000) begin @(negedge clk); n++; end
    check(dut_hs == ROWS * COLS, "frame_c_handshakes", dut_hs, ROWS * COLS);
    @(posedge clk); #1 load_sw = 1'b0;
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
